pe_col_dispatch: RTL and testbench
==================================

# pe_col_dispatch

Issuing side of the PE column handshake: the block that feeds each PE column controller.
- Takes a stream of 6-element activation groups and computes a per-group nonzero guard map.
- Issues each group with its row metadata on a valid/ready handshake, then waits for the controller's finish pulse before issuing the next group.
- Sits between the activation buffer and one PE column, and walks a configured rows × groups frame.

## Interface
Parameters:
- DATA_W, 8, activation element width
- GRP_CNT_W, 8, width of group-per-row counter
- ROW_CNT_W, 8, width of row counter

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; accepted only in IDLE
- cfg_bit_mode  in  1  4-bit mode; latched at start
- cfg_kernal_mode  in  1  kernel mode; latched at start
- cfg_num_groups  in  GRP_CNT_W  groups per row; latched at start
- cfg_num_rows  in  ROW_CNT_W  rows per frame; latched at start
- act_valid  in  1  activation group available
- act_ready  out  1  group accepted when act_valid && act_ready
- act_data  in  6*DATA_W  element k at [k*DATA_W +: DATA_W]
- valid  out  1  issue request to column controller
- ready  in  1  controller ready
- finish  in  1  controller done with current group (one-cycle pulse)
- bit_mode_o, kernal_mode_o  out  1 each  latched config
- guard_map_o  out  6  nonzero map of issued group
- is_odd_row_o  out  1  row parity of issued group
- end_of_row_o  out  1  issued group is last in its row
- act_data_o  out  6*DATA_W  issued group, held stable
- busy  out  1  high from start accept to done
- done  out  1  one-cycle pulse at frame end

## Operation
- FSM states: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE:
  - On start, latch the config and clear row_cnt and grp_cnt.
  - If cfg_num_groups==0 or cfg_num_rows==0, go to DONE. Otherwise go to FETCH.
- FETCH:
  - act_ready=1.
  - On act_valid, register act_data into act_data_o and compute guard_map_o, end_of_row_o and is_odd_row_o. Go to ISSUE.
- guard_map_o:
  - Bit 5-k = (element k != 0), so element 0 maps to the MSB, which the controller processes first.
  - In bit_mode the map is forced to 6'b111111 (dense).
  - An all-zero group is still issued with guard_map_o=0.
- ISSUE:
  - valid=1, with all payload outputs stable.
  - On valid && ready, go to WAIT.
- WAIT:
  - valid=0.
  - On finish, advance counters: grp_cnt++; at num_groups-1, wrap grp_cnt to 0 and increment row_cnt.
  - If the finished group was the last of the last row, go to DONE. Otherwise go to FETCH.
- DONE: pulse done for one cycle, then go to IDLE.
- is_odd_row_o = ~row_cnt[0]: row 0 is the first, odd row.
- end_of_row_o = (grp_cnt == num_groups-1).
- start outside IDLE is ignored.
- A finish pulse seen outside WAIT is ignored.

## Timing
- Reset values: state=IDLE; all outputs 0, including act_ready, valid, busy, done, guard_map_o, act_data_o and counters.
- Outputs are registered except act_ready and valid, which decode the current state.
- start at cycle t → busy and act_ready high at t+1.
- Group accepted at t → valid high at t+1.
- valid must not drop and the payload must not change until ready is sampled high.
- valid is never asserted while a previous group awaits finish.
- A finish arriving in the same cycle as the handshake is not possible per the controller; it is treated as belonging to the next WAIT only.
- finish at t → act_ready at t+1, so the next issue is no earlier than t+2.
- Last finish at t → done pulses at t+1; busy clears at t+2.
- Reset asserted mid-frame returns to IDLE asynchronously. Any in-flight group is dropped and no done is produced.

## Structure
- Shared package diff_core_pkg.sv gets:
  - dispatch state enum dispatch_state_t {IDLE, FETCH, ISSUE, WAIT, DONE}, prefixed D_ to avoid clashing with PE_state_t literals.
  - Constant PE_GROUP_SIZE=6.
- One sub-module, guard_map_gen: combinational; takes 6*DATA_W data and bit_mode, returns the 6-bit map.

## Test plan
- Frame rows=2, groups=3, dense nonzero data; controller model with ready always 1, finish 2 cycles after accept:
  - 6 issues; is_odd_row_o sequence 1,1,1,0,0,0.
  - end_of_row_o on issues 3 and 6.
  - One done pulse.
- Group {0,5,0,0,7,0}, bit_mode=0 → guard_map_o=6'b010010. Same group with bit_mode=1 → 6'b111111.
- All-zero group → issued with guard_map_o=0; next fetch only after finish.
- ready held low 10 cycles during ISSUE → valid stays high and payload stays constant; exactly one handshake occurs.
- cfg_num_groups=0 → done at start+1; valid never asserted.
- rst_n low during WAIT → all outputs 0 immediately; a new start then runs a full frame correctly.

Source files
------------

// File: rtl/diff_core_pkg.sv
// Shared definitions for the PE column datapath: group geometry and dispatch FSM states.
package diff_core_pkg;

    localparam int unsigned PE_GROUP_SIZE    = 6;
    localparam int unsigned DISPATCH_STATE_W = 3;

    // D_ prefix keeps these literals distinct from the PE controller's own state names.
    typedef enum logic [DISPATCH_STATE_W-1:0] {
        D_IDLE  = 3'd0,
        D_FETCH = 3'd1,
        D_ISSUE = 3'd2,
        D_WAIT  = 3'd3,
        D_DONE  = 3'd4
    } dispatch_state_t;

endpackage

// File: rtl/pe_col_dispatch_guard_map_gen.sv
// Per-group nonzero guard map: element 0 lands on the MSB, which the column controller
// processes first. In 4-bit mode every lane is treated as occupied.
module guard_map_gen
    import diff_core_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [PE_GROUP_SIZE*DATA_W-1:0] data_i,
    input  logic                            bit_mode_i,
    output logic [PE_GROUP_SIZE-1:0]        guard_map_c
);

    always_comb begin
        guard_map_c = '0;
        for (int k = 0; k < PE_GROUP_SIZE; k++) begin
            guard_map_c[PE_GROUP_SIZE-1-k] = |data_i[k*DATA_W +: DATA_W];
        end
        if (bit_mode_i) begin
            guard_map_c = '1;
        end
    end

endmodule

// File: rtl/pe_col_dispatch.sv
// Issuing side of the PE column handshake: walks a rows x groups frame, fetching one
// activation group at a time and holding it on valid/ready until the controller finishes it.
module pe_col_dispatch
    import diff_core_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned GRP_CNT_W = 8,
    parameter int unsigned ROW_CNT_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            cfg_bit_mode,
    input  logic                            cfg_kernal_mode,
    input  logic [GRP_CNT_W-1:0]            cfg_num_groups,
    input  logic [ROW_CNT_W-1:0]            cfg_num_rows,
    input  logic                            act_valid,
    output logic                            act_ready,
    input  logic [PE_GROUP_SIZE*DATA_W-1:0] act_data,
    output logic                            valid,
    input  logic                            ready,
    input  logic                            finish,
    output logic                            bit_mode_o,
    output logic                            kernal_mode_o,
    output logic [PE_GROUP_SIZE-1:0]        guard_map_o,
    output logic                            is_odd_row_o,
    output logic                            end_of_row_o,
    output logic [PE_GROUP_SIZE*DATA_W-1:0] act_data_o,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned GRP_W = PE_GROUP_SIZE * DATA_W;

    dispatch_state_t          state_q,       state_d;
    logic                     bit_mode_q,    bit_mode_d;
    logic                     kernal_mode_q, kernal_mode_d;
    logic [GRP_CNT_W-1:0]     num_groups_q,  num_groups_d;
    logic [ROW_CNT_W-1:0]     num_rows_q,    num_rows_d;
    logic [GRP_CNT_W-1:0]     grp_cnt_q,     grp_cnt_d;
    logic [ROW_CNT_W-1:0]     row_cnt_q,     row_cnt_d;
    logic [PE_GROUP_SIZE-1:0] guard_map_q,   guard_map_d;
    logic                     is_odd_row_q,  is_odd_row_d;
    logic                     end_of_row_q,  end_of_row_d;
    logic [GRP_W-1:0]         act_data_q,    act_data_d;
    logic                     busy_q,        busy_d;
    logic                     done_q,        done_d;

    logic [PE_GROUP_SIZE-1:0] guard_map_c;
    logic                     last_grp_c;
    logic                     last_row_c;
    logic                     empty_cfg_c;

    // Map is built from the latched mode so a mid-frame cfg change cannot leak in.
    guard_map_gen #(
        .DATA_W (DATA_W)
    ) u_guard_map_gen (
        .data_i      (act_data),
        .bit_mode_i  (bit_mode_q),
        .guard_map_c (guard_map_c)
    );

    assign last_grp_c  = (grp_cnt_q == num_groups_q - GRP_CNT_W'(1));
    assign last_row_c  = (row_cnt_q == num_rows_q - ROW_CNT_W'(1));
    assign empty_cfg_c = (cfg_num_groups == '0) || (cfg_num_rows == '0);

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        bit_mode_d    = bit_mode_q;
        kernal_mode_d = kernal_mode_q;
        num_groups_d  = num_groups_q;
        num_rows_d    = num_rows_q;
        grp_cnt_d     = grp_cnt_q;
        row_cnt_d     = row_cnt_q;
        guard_map_d   = guard_map_q;
        is_odd_row_d  = is_odd_row_q;
        end_of_row_d  = end_of_row_q;
        act_data_d    = act_data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        case (state_q)
            D_IDLE: begin
                if (start) begin
                    bit_mode_d    = cfg_bit_mode;
                    kernal_mode_d = cfg_kernal_mode;
                    num_groups_d  = cfg_num_groups;
                    num_rows_d    = cfg_num_rows;
                    grp_cnt_d     = '0;
                    row_cnt_d     = '0;
                    busy_d        = 1'b1;
                    if (empty_cfg_c) begin
                        state_d = D_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = D_FETCH;
                    end
                end
            end

            D_FETCH: begin
                if (act_valid) begin
                    act_data_d   = act_data;
                    guard_map_d  = guard_map_c;
                    is_odd_row_d = ~row_cnt_q[0];
                    end_of_row_d = last_grp_c;
                    state_d      = D_ISSUE;
                end
            end

            D_ISSUE: begin
                if (ready) begin
                    state_d = D_WAIT;
                end
            end

            D_WAIT: begin
                if (finish) begin
                    if (last_grp_c) begin
                        grp_cnt_d = '0;
                        row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
                    end else begin
                        grp_cnt_d = grp_cnt_q + GRP_CNT_W'(1);
                    end
                    if (last_grp_c && last_row_c) begin
                        state_d = D_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = D_FETCH;
                    end
                end
            end

            D_DONE: begin
                busy_d  = 1'b0;
                state_d = D_IDLE;
            end

            default: begin
                state_d = D_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= D_IDLE;
            bit_mode_q    <= 1'b0;
            kernal_mode_q <= 1'b0;
            num_groups_q  <= '0;
            num_rows_q    <= '0;
            grp_cnt_q     <= '0;
            row_cnt_q     <= '0;
            guard_map_q   <= '0;
            is_odd_row_q  <= 1'b0;
            end_of_row_q  <= 1'b0;
            act_data_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_mode_q    <= bit_mode_d;
            kernal_mode_q <= kernal_mode_d;
            num_groups_q  <= num_groups_d;
            num_rows_q    <= num_rows_d;
            grp_cnt_q     <= grp_cnt_d;
            row_cnt_q     <= row_cnt_d;
            guard_map_q   <= guard_map_d;
            is_odd_row_q  <= is_odd_row_d;
            end_of_row_q  <= end_of_row_d;
            act_data_q    <= act_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Handshake strobes decode the state directly so they track it with no extra cycle.
    assign act_ready     = (state_q == D_FETCH);
    assign valid         = (state_q == D_ISSUE);
    assign bit_mode_o    = bit_mode_q;
    assign kernal_mode_o = kernal_mode_q;
    assign guard_map_o   = guard_map_q;
    assign is_odd_row_o  = is_odd_row_q;
    assign end_of_row_o  = end_of_row_q;
    assign act_data_o    = act_data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_pe_col_dispatch.sv
// Scoreboard bench for pe_col_dispatch: frames of random groups against a frame-level model,
// with a small column-controller model answering ready/finish.
module tb_pe_col_dispatch;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned GRP_CNT_W = 8;
    localparam int unsigned ROW_CNT_W = 8;
    localparam int unsigned GW        = 6 * DATA_W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 cfg_bit_mode;
    logic                 cfg_kernal_mode;
    logic [GRP_CNT_W-1:0] cfg_num_groups;
    logic [ROW_CNT_W-1:0] cfg_num_rows;
    logic                 act_valid;
    logic                 act_ready;
    logic [GW-1:0]        act_data;
    logic                 valid;
    logic                 ready;
    logic                 finish;
    logic                 bit_mode_o;
    logic                 kernal_mode_o;
    logic [5:0]           guard_map_o;
    logic                 is_odd_row_o;
    logic                 end_of_row_o;
    logic [GW-1:0]        act_data_o;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    pe_col_dispatch #(
        .DATA_W    (DATA_W),
        .GRP_CNT_W (GRP_CNT_W),
        .ROW_CNT_W (ROW_CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_bit_mode    (cfg_bit_mode),
        .cfg_kernal_mode (cfg_kernal_mode),
        .cfg_num_groups  (cfg_num_groups),
        .cfg_num_rows    (cfg_num_rows),
        .act_valid       (act_valid),
        .act_ready       (act_ready),
        .act_data        (act_data),
        .valid           (valid),
        .ready           (ready),
        .finish          (finish),
        .bit_mode_o      (bit_mode_o),
        .kernal_mode_o   (kernal_mode_o),
        .guard_map_o     (guard_map_o),
        .is_odd_row_o    (is_odd_row_o),
        .end_of_row_o    (end_of_row_o),
        .act_data_o      (act_data_o),
        .busy            (busy),
        .done            (done)
    );

    typedef struct {
        logic [GW-1:0] data;
        logic [5:0]    gm;
        logic          odd;
        logic          eor;
        logic          bm;
        logic          km;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   cyc          = 0;
    int   hs_count     = 0;
    int   hs_taken     = 0;
    int   done_cnt     = 0;
    int   valid_cnt    = 0;
    int   last_fin_cyc = 0;
    int   fin_cnt      = 0;
    int   fin_delay    = 2;
    int   hold_left    = 0;
    bit   rand_ready   = 1'b0;
    bit   zero_frame   = 1'b0;
    bit   awaiting     = 1'b0;
    bit   prev_valid   = 1'b0;
    bit   prev_ready   = 1'b0;
    bit   prev_done    = 1'b0;
    logic [GW-1:0] prev_data;
    logic [5:0]    prev_gm;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait expired (cycle %0d)", name, cyc);
    endtask

    // Nonzero map from the element list: element k present -> bit (5-k); 4-bit mode is dense.
    function automatic logic [5:0] model_gm(input logic [GW-1:0] d, input logic bm);
        logic [5:0] m;
        m = '0;
        if (bm) return 6'b111111;
        for (int k = 0; k < 6; k++) begin
            if (d[k*DATA_W +: DATA_W] != '0) m[5-k] = 1'b1;
        end
        return m;
    endfunction

    // pat: 0 dense nonzero, 1 sparse, 2 all zero, 3 fixed {0,5,0,0,7,0}
    function automatic logic [GW-1:0] make_group(input int pat);
        logic [GW-1:0] g;
        logic [7:0]    fixed [6];
        fixed = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd7, 8'd0};
        g = '0;
        for (int k = 0; k < 6; k++) begin
            case (pat)
                0:       g[k*DATA_W +: DATA_W] = 8'($urandom_range(1, 255));
                1:       g[k*DATA_W +: DATA_W] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                3:       g[k*DATA_W +: DATA_W] = fixed[k];
                default: g[k*DATA_W +: DATA_W] = 8'd0;
            endcase
        end
        return g;
    endfunction

    // Monitor: scoreboard pops, payload stability, wait-phase exclusivity, done timing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            awaiting   = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_done) check("busy_clear_after_done", 64'(busy), 64'(0));
            prev_done = done;
            if (done) begin
                done_cnt++;
                if (!zero_frame) check("done_latency", 64'(cyc - last_fin_cyc), 64'(1));
            end
            if (valid) valid_cnt++;
            if (prev_valid && !prev_ready) begin
                check("valid_held", 64'(valid), 64'(1));
                check("payload_held", 64'(act_data_o), 64'(prev_data));
                check("guard_held", 64'(guard_map_o), 64'(prev_gm));
            end
            if (awaiting) begin
                check("no_valid_in_wait", 64'(valid), 64'(0));
                check("no_fetch_in_wait", 64'(act_ready), 64'(0));
                if (finish) begin
                    awaiting     = 1'b0;
                    last_fin_cyc = cyc;
                end
            end
            if (valid && ready) begin
                hs_count++;
                awaiting = 1'b1;
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_issue");
                end else begin
                    e = exp_q.pop_front();
                    check("issue_data", 64'(act_data_o), 64'(e.data));
                    check("issue_guard", 64'(guard_map_o), 64'(e.gm));
                    check("issue_odd_row", 64'(is_odd_row_o), 64'(e.odd));
                    check("issue_end_of_row", 64'(end_of_row_o), 64'(e.eor));
                    check("issue_bit_mode", 64'(bit_mode_o), 64'(e.bm));
                    check("issue_kernal_mode", 64'(kernal_mode_o), 64'(e.km));
                end
            end
            prev_valid = valid;
            prev_ready = ready;
            prev_data  = act_data_o;
            prev_gm    = guard_map_o;
        end
    end

    // Column controller model: ready policy plus a finish pulse after each accepted issue.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            finish   = 1'b0;
            fin_cnt  = 0;
            hs_taken = hs_count;
        end else begin
            finish = 1'b0;
            if (fin_cnt > 0) begin
                fin_cnt--;
                if (fin_cnt == 0) finish = 1'b1;
            end
            if (hs_taken != hs_count) begin
                hs_taken = hs_count;
                fin_cnt  = fin_delay - 1;
            end
            if (hold_left > 0) begin
                ready = 1'b0;
                if (valid) hold_left--;
            end else begin
                ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_act_ready"}, 64'(act_ready), 64'(0));
        check({tag, "_valid"}, 64'(valid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_guard_map"}, 64'(guard_map_o), 64'(0));
        check({tag, "_act_data"}, 64'(act_data_o), 64'(0));
        check({tag, "_flags"}, 64'({bit_mode_o, kernal_mode_o, is_odd_row_o, end_of_row_o}), 64'(0));
    endtask

    task automatic send_group(input logic [GW-1:0] g);
        bit ok;
        act_valid = 1'b1;
        act_data  = g;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (act_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("accept_timeout");
        @(posedge clk);
        #1;
        act_valid = 1'b0;
        act_data  = GW'({$urandom, $urandom});
    endtask

    task automatic run_frame(input int rows, input int groups, input logic bm, input logic km,
                             input int pat, input bit poke);
        logic [GW-1:0] grps[$];
        logic [GW-1:0] g;
        exp_t          e;
        int            d0, h0, v0;
        bit            ok;
        for (int i = 0; i < rows * groups; i++) begin
            g = make_group(pat);
            grps.push_back(g);
            e.data = g;
            e.gm   = model_gm(g, bm);
            e.odd  = ((i / groups) % 2 == 0);
            e.eor  = ((i % groups) == groups - 1);
            e.bm   = bm;
            e.km   = km;
            exp_q.push_back(e);
        end
        zero_frame = (rows == 0) || (groups == 0);
        d0 = done_cnt;
        h0 = hs_count;
        v0 = valid_cnt;
        @(posedge clk);
        #1;
        cfg_bit_mode    = bm;
        cfg_kernal_mode = km;
        cfg_num_groups  = GRP_CNT_W'(groups);
        cfg_num_rows    = ROW_CNT_W'(rows);
        start           = 1'b1;
        @(posedge clk);
        #1;
        start           = 1'b0;
        cfg_bit_mode    = 1'($urandom);
        cfg_kernal_mode = 1'($urandom);
        cfg_num_groups  = GRP_CNT_W'($urandom);
        cfg_num_rows    = ROW_CNT_W'($urandom);
        check("busy_at_start_plus1", 64'(busy), 64'(1));
        if (zero_frame) begin
            check("done_at_start_plus1", 64'(done), 64'(1));
            check("no_fetch_empty_frame", 64'(act_ready), 64'(0));
        end else begin
            check("act_ready_at_start_plus1", 64'(act_ready), 64'(1));
        end
        for (int i = 0; i < grps.size(); i++) begin
            send_group(grps[i]);
            if (poke && i == 0) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout_fail("done_timeout");
        repeat (2) @(posedge clk);
        #1;
        check("one_done_per_frame", 64'(done_cnt - d0), 64'(1));
        check("issue_count", 64'(hs_count - h0), 64'(rows * groups));
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        check("idle_after_frame", 64'({busy, valid, act_ready}), 64'(0));
        if (zero_frame) check("no_valid_empty_frame", 64'(valid_cnt - v0), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [GW-1:0] g;
        exp_t          e;
        bit            ok;
        int            d0;
        rst_n           = 1'b0;
        start           = 1'b0;
        cfg_bit_mode    = 1'b0;
        cfg_kernal_mode = 1'b0;
        cfg_num_groups  = '0;
        cfg_num_rows    = '0;
        act_valid       = 1'b0;
        act_data        = '0;
        ready           = 1'b1;
        finish          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Basic 2x3 frame, ready always high, finish two cycles after accept.
        fin_delay = 2;
        run_frame(2, 3, 1'b0, 1'b1, 0, 1'b0);

        run_frame(1, 1, 1'b0, 1'b0, 3, 1'b0);
        check("sparse_guard_010010", 64'(guard_map_o), 64'(6'b010010));
        run_frame(1, 1, 1'b1, 1'b0, 3, 1'b0);
        check("bit_mode_guard_dense", 64'(guard_map_o), 64'(6'b111111));

        fin_delay = 4;
        run_frame(1, 2, 1'b0, 1'b1, 2, 1'b0);
        check("all_zero_guard", 64'(guard_map_o), 64'(0));

        hold_left = 10;
        run_frame(1, 2, 1'b0, 1'b0, 0, 1'b0);

        run_frame(3, 0, 1'b0, 1'b0, 0, 1'b0);
        run_frame(0, 2, 1'b1, 1'b1, 0, 1'b0);

        // Reset while the first group is outstanding.
        fin_delay = 6;
        g = make_group(0);
        e.data = g; e.gm = model_gm(g, 1'b0); e.odd = 1'b1; e.eor = 1'b0; e.bm = 1'b0; e.km = 1'b1;
        exp_q.push_back(e);
        zero_frame = 1'b0;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        cfg_bit_mode = 1'b0; cfg_kernal_mode = 1'b1;
        cfg_num_groups = GRP_CNT_W'(3); cfg_num_rows = ROW_CNT_W'(2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_group(g);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (awaiting) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("reset_test_issue_timeout");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midframe_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("no_done_on_reset", 64'(done_cnt - d0), 64'(0));
        rst_n = 1'b1;
        fin_delay = 2;
        run_frame(2, 3, 1'b0, 1'b1, 0, 1'b0);

        // Randomized frames with random ready, finish latency, modes and stray starts.
        rand_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            fin_delay = $urandom_range(2, 5);
            run_frame($urandom_range(1, 4), $urandom_range(1, 5), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 1), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
